pe_result_collector: RTL and testbench

- Downstream drain stage for the last PE in a row. Consumes the PE's O_DataOut/O_DataOutValid partial-sum stream through a valid/ready handshake and drives the PE's O_DataOutRdy.
- Packs PackFactor consecutive results into one wide word, buffers the wide words in a FIFO and emits them to memory writeback.
- Counts results per tile, flags the last word of a tile and pulses Done once the tile has fully drained.

---
 rtl/pe_result_collector.sv | 190 +++++++++++++++++++
 tb/tb_pe_result_collector.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Drain stage for the last PE of a row: packs partial sums into wide
// words, buffers them and flags the final word of each tile.
module pe_result_collector #(
    parameter int DataWidth   = 32,
    parameter int PackFactor  = 2,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int CountWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Start,
    input  logic [CountWidth-1:0]           TileLen,
    input  logic                            DataInValid,
    output logic                            DataInRdy,
    input  logic [DataWidth-1:0]            DataIn,
    output logic                            DataOutValid,
    input  logic                            DataOutRdy,
    output logic [DataWidth*PackFactor-1:0] DataOut,
    output logic [PackFactor-1:0]           DataOutMask,
    output logic                            DataOutLast,
    output logic                            Busy,
    output logic                            Done
);

    localparam int LaneWidth = (PackFactor > 1) ? $clog2(PackFactor) : 1;
    localparam int WordWidth = DataWidth * PackFactor;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    logic [CountWidth-1:0]  tileLen;
    logic [CountWidth-1:0]  count;
    logic [CountWidth-1:0]  countInc;
    logic [LaneWidth-1:0]   lane;
    logic [WordWidth-1:0]   packData;
    logic [PackFactor-1:0]  packMask;
    logic [WordWidth-1:0]   mergedData;
    logic [PackFactor-1:0]  mergedMask;
    logic                   doneReg;

    logic [WordWidth-1:0]   fifoData [BufferSize];
    logic [PackFactor-1:0]  fifoMask [BufferSize];
    logic                   fifoLast [BufferSize];
    logic [BufferWidth-1:0] wrPtr;
    logic [BufferWidth-1:0] rdPtr;
    logic [BufferWidth:0]   used;
    logic [BufferWidth:0]   usedNext;

    logic fifoFull;
    logic fifoEmpty;
    logic accept;
    logic pop;
    logic push;
    logic laneLast;
    logic lastResult;

    assign fifoFull   = (used == (BufferWidth+1)'(BufferSize));
    assign fifoEmpty  = (used == '0);
    assign DataInRdy  = (state == COLLECT) & ~fifoFull;
    assign accept     = DataInValid & DataInRdy;
    assign pop        = DataOutValid & DataOutRdy;
    assign countInc   = count + CountWidth'(1);
    assign lastResult = (countInc == tileLen);
    assign laneLast   = (lane == LaneWidth'(PackFactor - 1));
    assign push       = accept & (laneLast | lastResult);

    always_comb begin
        mergedData = packData;
        mergedMask = packMask;
        for (int k = 0; k < PackFactor; k++) begin
            if (lane == LaneWidth'(k)) begin
                mergedData[k*DataWidth +: DataWidth] = DataIn;
                mergedMask[k] = 1'b1;
            end
        end
    end

    always_comb begin
        usedNext = used;
        unique case ({push, pop})
            2'b10:   usedNext = used + (BufferWidth+1)'(1);
            2'b01:   usedNext = used - (BufferWidth+1)'(1);
            default: usedNext = used;
        endcase
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    stateNext = (TileLen == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (accept && lastResult) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (usedNext == '0) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tileLen  <= '0;
            count    <= '0;
            lane     <= '0;
            packData <= '0;
            packMask <= '0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= (state == DONE);
            if (state == IDLE && Start && TileLen != '0) begin
                tileLen  <= TileLen;
                count    <= '0;
                lane     <= '0;
                packData <= '0;
                packMask <= '0;
            end
            if (accept) begin
                count <= countInc;
                if (push) begin
                    packData <= '0;
                    packMask <= '0;
                    lane     <= '0;
                end else begin
                    packData <= mergedData;
                    packMask <= mergedMask;
                    lane     <= lane + LaneWidth'(1);
                end
            end
        end
    end

    // Storage carries no reset; the head is gated by the occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoData[wrPtr] <= mergedData;
            fifoMask[wrPtr] <= mergedMask;
            fifoLast[wrPtr] <= lastResult;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            used  <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + BufferWidth'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + BufferWidth'(1);
            end
            used <= usedNext;
        end
    end

    assign DataOutValid = ~fifoEmpty;
    assign DataOut      = fifoEmpty ? '0 : fifoData[rdPtr];
    assign DataOutMask  = fifoEmpty ? '0 : fifoMask[rdPtr];
    assign DataOutLast  = fifoEmpty ? 1'b0 : fifoLast[rdPtr];
    assign Busy         = (state != IDLE);
    assign Done         = doneReg;

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: vector table of tiles plus hand-written
// backpressure, zero-length, mid-tile reset and ignored-Start sequences.
module tb_pe_result_collector;

    localparam int DW = 32;
    localparam int PF = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              Start = 1'b0;
    logic [15:0]       TileLen = '0;
    logic              DataInValid = 1'b0;
    logic              DataInRdy;
    logic [DW-1:0]     DataIn = '0;
    logic              DataOutValid;
    logic              DataOutRdy = 1'b0;
    logic [DW*PF-1:0]  DataOut;
    logic [PF-1:0]     DataOutMask;
    logic              DataOutLast;
    logic              Busy;
    logic              Done;

    pe_result_collector #(
        .DataWidth(DW), .PackFactor(PF), .BufferWidth(2),
        .BufferSize(4), .CountWidth(16)
    ) dut (
        .clk(clk), .rst(rst), .Start(Start), .TileLen(TileLen),
        .DataInValid(DataInValid), .DataInRdy(DataInRdy), .DataIn(DataIn),
        .DataOutValid(DataOutValid), .DataOutRdy(DataOutRdy),
        .DataOut(DataOut), .DataOutMask(DataOutMask),
        .DataOutLast(DataOutLast), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*PF-1:0] data;
        logic [PF-1:0]    mask;
        logic             last;
    } expT;

    typedef struct {
        int          len;
        logic [31:0] base;
        logic [31:0] step;
        int          mode;
        int          expWords;
    } vecT;

    expT sb[$];
    int  checks = 0;
    int  failures = 0;
    int  popCnt = 0;
    int  doneCnt = 0;
    int  rdyMode = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 0 = stalled, 1 = always ready, otherwise random
    always @(posedge clk) begin
        #2;
        case (rdyMode)
            0:       DataOutRdy = 1'b0;
            1:       DataOutRdy = 1'b1;
            default: DataOutRdy = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        expT e;
        if (!rst && DataOutValid && DataOutRdy) begin
            popCnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got %h expected none", DataOut);
            end else begin
                e = sb.pop_front();
                check("word_data", DataOut, e.data);
                check("word_mask", 64'(DataOutMask), 64'(e.mask));
                check("word_last", 64'(DataOutLast), 64'(e.last));
            end
        end
        if (!rst && Done) begin
            doneCnt++;
            check("busy_low_at_done", 64'(Busy), 64'd0);
        end
    end

    function automatic logic [31:0] gen(input logic [31:0] base,
                                        input logic [31:0] step, input int i);
        return base + step * 32'(i);
    endfunction

    task automatic modelTile(input int len, input logic [31:0] base,
                             input logic [31:0] step);
        expT e;
        e.data = '0;
        e.mask = '0;
        e.last = 1'b0;
        for (int i = 0; i < len; i++) begin
            e.data[(i % PF) * DW +: DW] = gen(base, step, i);
            e.mask[i % PF] = 1'b1;
            if ((i % PF) == PF - 1 || i == len - 1) begin
                e.last = (i == len - 1);
                sb.push_back(e);
                e.data = '0;
                e.mask = '0;
            end
        end
    endtask

    task automatic pulseStart(input int len);
        Start = 1'b1;
        TileLen = 16'(len);
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic sendData(input logic [31:0] d);
        int  n;
        logic r;
        n = 0;
        DataInValid = 1'b1;
        DataIn = d;
        do begin
            @(negedge clk);
            r = DataInRdy;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 2000);
        if (!r) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got rdy=0 expected rdy=1");
        end
    endtask

    task automatic waitDone(input int d0);
        int n;
        n = 0;
        while (doneCnt == d0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_seen", 64'(doneCnt - d0), 64'd1);
    endtask

    task automatic runTile(input vecT v);
        int d0;
        int p0;
        d0 = doneCnt;
        p0 = popCnt;
        rdyMode = v.mode;
        modelTile(v.len, v.base, v.step);
        pulseStart(v.len);
        for (int i = 0; i < v.len; i++) sendData(gen(v.base, v.step, i));
        DataInValid = 1'b0;
        waitDone(d0);
        check("tile_words", 64'(popCnt - p0), 64'(v.expWords));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vecT vecs[6];
        vecT v;
        int  d0;
        int  p0;

        vecs[0] = '{len: 4,  base: 32'h11,   step: 32'h11, mode: 1, expWords: 2};
        vecs[1] = '{len: 3,  base: 32'hA,    step: 32'h1,  mode: 1, expWords: 2};
        vecs[2] = '{len: 1,  base: 32'hBEEF, step: 32'h0,  mode: 1, expWords: 1};
        vecs[3] = '{len: 7,  base: 32'h1000, step: 32'h3,  mode: 2, expWords: 4};
        vecs[4] = '{len: 16, base: 32'hF000, step: 32'h7,  mode: 2, expWords: 8};
        vecs[5] = '{len: 5,  base: 32'hC0DE, step: 32'h10, mode: 1, expWords: 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_inrdy", 64'(DataInRdy), 64'd0);
        check("rst_outvalid", 64'(DataOutValid), 64'd0);
        check("rst_dataout", DataOut, 64'd0);
        check("rst_mask", 64'(DataOutMask), 64'd0);
        check("rst_last", 64'(DataOutLast), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) runTile(vecs[t]);

        // backpressure: 12 results with writeback stalled
        rdyMode = 0;
        p0 = popCnt;
        d0 = doneCnt;
        modelTile(12, 32'h200, 32'h1);
        pulseStart(12);
        for (int i = 0; i < 8; i++) sendData(gen(32'h200, 32'h1, i));
        DataInValid = 1'b0;
        @(negedge clk);
        check("bp_full_inrdy", 64'(DataInRdy), 64'd0);
        check("bp_full_outvalid", 64'(DataOutValid), 64'd1);
        rdyMode = 1;
        @(negedge clk);
        check("bp_pop_cycle_inrdy", 64'(DataInRdy), 64'd0);
        rdyMode = 0;
        @(negedge clk);
        check("bp_after_pop_inrdy", 64'(DataInRdy), 64'd1);
        check("bp_one_pop", 64'(popCnt - p0), 64'd1);
        @(posedge clk); #1;
        rdyMode = 1;
        for (int i = 8; i < 12; i++) sendData(gen(32'h200, 32'h1, i));
        DataInValid = 1'b0;
        waitDone(d0);
        check("bp_words", 64'(popCnt - p0), 64'd6);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // zero-length tile
        @(posedge clk); #1;
        d0 = doneCnt;
        pulseStart(0);
        @(negedge clk);
        check("zero_done_early", 64'(Done), 64'd0);
        check("zero_busy", 64'(Busy), 64'd1);
        @(negedge clk);
        check("zero_done", 64'(Done), 64'd1);
        check("zero_outvalid", 64'(DataOutValid), 64'd0);
        @(negedge clk);
        check("zero_done_once", 64'(doneCnt - d0), 64'd1);
        @(posedge clk); #1;

        // reset mid-tile with one buffered word and a half-filled lane
        rdyMode = 0;
        pulseStart(6);
        for (int i = 0; i < 3; i++) sendData(32'hDEAD0000 + 32'(i));
        DataInValid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_outvalid", 64'(DataOutValid), 64'd0);
        check("mid_rst_dataout", DataOut, 64'd0);
        check("mid_rst_mask", 64'(DataOutMask), 64'd0);
        check("mid_rst_last", 64'(DataOutLast), 64'd0);
        check("mid_rst_busy", 64'(Busy), 64'd0);
        check("mid_rst_inrdy", 64'(DataInRdy), 64'd0);
        @(posedge clk); #1;
        v = '{len: 2, base: 32'h55, step: 32'h11, mode: 1, expWords: 1};
        runTile(v);

        // Start during COLLECT and DRAIN is ignored
        @(posedge clk); #1;
        rdyMode = 0;
        d0 = doneCnt;
        p0 = popCnt;
        modelTile(4, 32'h300, 32'h1);
        pulseStart(4);
        for (int i = 0; i < 2; i++) sendData(gen(32'h300, 32'h1, i));
        DataInValid = 1'b0;
        pulseStart(2);
        for (int i = 2; i < 4; i++) sendData(gen(32'h300, 32'h1, i));
        DataInValid = 1'b0;
        pulseStart(1);
        @(negedge clk);
        check("ign_drain_busy", 64'(Busy), 64'd1);
        rdyMode = 1;
        waitDone(d0);
        repeat (6) @(negedge clk);
        check("ign_words", 64'(popCnt - p0), 64'd2);
        check("ign_one_done", 64'(doneCnt - d0), 64'd1);
        check("ign_idle", 64'(Busy), 64'd0);
        check("ign_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
